muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 13 +
 rtl/muldiv_datapath.sv | 55 +++++
 rtl/muldiv_unit.sv | 140 ++++++++++++++
 tb/tb_muldiv_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states, default width.
package muldiv_pkg;
   localparam int XLEN_DEF = 32;

   localparam logic [1:0] OP_MULTU = 2'b00;
   localparam logic [1:0] OP_MULT  = 2'b01;
   localparam logic [1:0] OP_DIVU  = 2'b10;
   localparam logic [1:0] OP_DIV   = 2'b11;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_CALC = 2'b01;
   localparam logic [1:0] S_FIX  = 2'b10;
endpackage

// File: rtl/muldiv_datapath.sv
// One-bit-per-cycle step engine: shift-add multiply or restoring divide on unsigned magnitudes.
// The multiplier/dividend lives in the low accumulator and is consumed as the result shifts in.
module muldiv_datapath import muldiv_pkg::*; #(
   parameter int XLEN   = XLEN_DEF,
   parameter bit DIV_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic            i_step,
   input  logic            i_is_div,
   input  logic [XLEN-1:0] i_lo_init,
   input  logic [XLEN-1:0] i_b_init,
   output logic [XLEN-1:0] o_acc_hi,
   output logic [XLEN-1:0] o_acc_lo
);
   logic [XLEN-1:0] r_hi, r_lo, r_b;
   logic [XLEN:0]   w_sum, w_shl;
   logic [XLEN+1:0] w_diff;
   logic            w_ge;
   logic [XLEN-1:0] w_nxt_hi, w_nxt_lo;

   always_comb begin
      w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      w_shl  = {r_hi, r_lo[XLEN-1]};
      // extra top bit of the difference is the borrow: set means divisor did not fit
      w_diff = {1'b0, w_shl} - {2'b00, r_b};
      w_ge   = ~w_diff[XLEN+1];
      if (DIV_EN && i_is_div) begin
         w_nxt_hi = w_ge ? w_diff[XLEN-1:0] : w_shl[XLEN-1:0];
         w_nxt_lo = {r_lo[XLEN-2:0], w_ge};
      end else begin
         w_nxt_hi = w_sum[XLEN:1];
         w_nxt_lo = {w_sum[0], r_lo[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_hi <= '0;
         r_lo <= '0;
         r_b  <= '0;
      end else if (i_load) begin
         r_hi <= '0;
         r_lo <= i_lo_init;
         r_b  <= i_b_init;
      end else if (i_step) begin
         r_hi <= w_nxt_hi;
         r_lo <= w_nxt_lo;
      end
   end

   assign o_acc_hi = r_hi;
   assign o_acc_lo = r_lo;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO writes.
// Divide support is compiled in only when MULDIV_DIV_EN is defined.
module muldiv_unit import muldiv_pkg::*; #(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            hi_we,
   input  logic            lo_we,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo,
   output logic            div_by_zero
);
`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam int CW = $clog2(XLEN);

   logic [1:0]        r_state;
   logic [CW-1:0]     r_cnt;
   logic              r_neg_res, r_done;
   logic [XLEN-1:0]   r_hi, r_lo;
   logic              w_accept, w_div_req, w_is_div, w_a_neg, w_b_neg;
   logic [XLEN-1:0]   w_a_mag, w_b_mag, w_acc_hi, w_acc_lo, w_res_hi, w_res_lo;
   logic [2*XLEN-1:0] w_prod;

   assign w_accept  = start & (r_state == S_IDLE) & (DIV_EN | ~op[1]);
   assign w_div_req = DIV_EN & op[1];
   assign w_a_neg   = op[0] & operand_a[XLEN-1];
   assign w_b_neg   = op[0] & operand_b[XLEN-1];
   assign w_a_mag   = w_a_neg ? -operand_a : operand_a;
   assign w_b_mag   = w_b_neg ? -operand_b : operand_b;

   muldiv_datapath #(.XLEN(XLEN), .DIV_EN(DIV_EN)) u_dp (
      .clk       (clk),
      .rst       (rst),
      .i_load    (w_accept),
      .i_step    (r_state == S_CALC),
      .i_is_div  (w_is_div),
      .i_lo_init (w_div_req ? w_a_mag : w_b_mag),
      .i_b_init  (w_div_req ? w_b_mag : w_a_mag),
      .o_acc_hi  (w_acc_hi),
      .o_acc_lo  (w_acc_lo)
   );

`ifdef MULDIV_DIV_EN
   logic            r_div, r_neg_rem, r_dbz, r_dbz_out;
   logic [XLEN-1:0] r_a_raw;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_div     <= 1'b0;
         r_neg_rem <= 1'b0;
         r_dbz     <= 1'b0;
         r_dbz_out <= 1'b0;
         r_a_raw   <= '0;
      end else begin
         r_dbz_out <= (r_state == S_FIX) & r_div & r_dbz;
         if (w_accept) begin
            r_div     <= op[1];
            r_neg_rem <= w_a_neg;
            r_dbz     <= op[1] & (operand_b == '0);
            r_a_raw   <= operand_a;
         end
      end
   end
   assign w_is_div    = r_div;
   assign div_by_zero = r_dbz_out;
`else
   assign w_is_div    = 1'b0;
   assign div_by_zero = 1'b0;
`endif

   // Sign correction; most-negative / -1 falls out naturally as 0x80..0 with zero remainder
   always_comb begin
      w_prod = r_neg_res ? -{w_acc_hi, w_acc_lo} : {w_acc_hi, w_acc_lo};
      {w_res_hi, w_res_lo} = w_prod;
`ifdef MULDIV_DIV_EN
      if (r_div) begin
         if (r_dbz) begin
            w_res_hi = r_a_raw;
            w_res_lo = '1;
         end else begin
            w_res_lo = r_neg_res ? -w_acc_lo : w_acc_lo;
            w_res_hi = r_neg_rem ? -w_acc_hi : w_acc_hi;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_neg_res <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state   <= S_CALC;
                  r_cnt     <= '0;
                  r_neg_res <= w_a_neg ^ w_b_neg;
               end else begin
                  if (hi_we) r_hi <= wdata;
                  if (lo_we) r_lo <= wdata;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + 1'b1;
               if (r_cnt == CW'(XLEN-1)) r_state <= S_FIX;
            end
            S_FIX: begin
               r_state <= S_IDLE;
               r_hi    <= w_res_hi;
               r_lo    <= w_res_lo;
               r_done  <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy = (r_state != S_IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases plus random ops against an arithmetic model.
module tb_muldiv_unit;
`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct packed {
      logic        dbz;
      logic [31:0] hi;
      logic [31:0] lo;
   } res_t;

   logic        clk = 1'b0;
   logic        rst, start, hi_we, lo_we;
   logic [1:0]  op;
   logic [31:0] operand_a, operand_b, wdata;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int   checks = 0;
   int   failures = 0;
   res_t exp_q[$];
   logic [31:0] m_hi = 32'h0, m_lo = 32'h0;

   always #5 clk = ~clk;

   muldiv_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .operand_a(operand_a), .operand_b(operand_b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Architectural result straight from signed/unsigned integer arithmetic
   function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      res_t r;
      longint sa, sb;
      logic [63:0] p;
      int ia, ib;
      r = '0;
      case (o)
         2'b00: begin p = {32'h0, a} * {32'h0, b}; {r.hi, r.lo} = p; end
         2'b01: begin sa = $signed(a); sb = $signed(b); p = sa * sb; {r.hi, r.lo} = p; end
         default: begin
            if (b == 32'h0) begin
               r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
            end else if (o == 2'b10) begin
               r.lo = a / b; r.hi = a % b;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               r.lo = 32'h8000_0000; r.hi = 32'h0;
            end else begin
               ia = $signed(a); ib = $signed(b);
               r.lo = ia / ib; r.hi = ia % ib;
            end
         end
      endcase
      return r;
   endfunction

   task automatic monitor();
      res_t r;
      forever begin
         @(negedge clk);
         if (done) begin
            if (exp_q.size() == 0) chk("spurious_done", done, 1'b0);
            else begin
               r = exp_q.pop_front();
               chk("res_hi", hi, r.hi);
               chk("res_lo", lo, r.lo);
               chk("res_dbz", div_by_zero, r.dbz);
            end
         end else chk("dbz_without_done", div_by_zero, 1'b0);
      end
   endtask

   // mode: 0 plain, 1 second start mid-op, 2 MT strobes while busy, 3 reset at cycle 10, 4 MT with start
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input int mode);
      int e;
      bit acc, bad_busy;
      res_t r;
      logic [31:0] old_hi, old_lo;
      acc = DIV_EN || !o[1];
      old_hi = m_hi; old_lo = m_lo;
      op = o; operand_a = a; operand_b = b; start = 1'b1;
      if (mode == 4) begin hi_we = 1'b1; lo_we = 1'b1; wdata = $urandom; end
      if (acc) begin
         r = model(o, a, b);
         exp_q.push_back(r);
         m_hi = r.hi; m_lo = r.lo;
      end
      @(posedge clk); #1;
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
      if (!acc) begin
         chk("ignored_busy", busy, 1'b0);
         chk("ignored_hi", hi, old_hi);
         chk("ignored_lo", lo, old_lo);
         return;
      end
      if (mode == 4) begin
         chk("mt_with_start_hi", hi, old_hi);
         chk("mt_with_start_lo", lo, old_lo);
      end
      e = 0; bad_busy = 1'b0;
      while (!done && e < 40) begin
         if (!busy) bad_busy = 1'b1;
         start = (mode == 1 && e == 5);
         if (start) begin op = 2'b00; operand_a = $urandom; operand_b = $urandom; end
         hi_we = (mode == 2 && e >= 3 && e <= 6); lo_we = hi_we; wdata = $urandom;
         if (mode == 3 && e == 10) rst = 1'b0;
         @(posedge clk); #1;
         e++;
         if (mode == 3 && e == 11) begin
            rst = 1'b1;
            void'(exp_q.pop_back());
            m_hi = 32'h0; m_lo = 32'h0;
            chk("rst_mid_busy", busy, 1'b0);
            chk("rst_mid_done", done, 1'b0);
            chk("rst_mid_hi", hi, 32'h0);
            chk("rst_mid_lo", lo, 32'h0);
            return;
         end
      end
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      chk("latency", e, 33);
      chk("busy_during_op", bad_busy, 1'b0);
      chk("busy_at_done", busy, 1'b0);
   endtask

   task automatic mt(input bit hw, input bit lw, input logic [31:0] d);
      hi_we = hw; lo_we = lw; wdata = d;
      @(posedge clk); #1;
      hi_we = 1'b0; lo_we = 1'b0;
      if (hw) m_hi = d;
      if (lw) m_lo = d;
      chk("mt_hi", hi, m_hi);
      chk("mt_lo", lo, m_lo);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      rst = 1'b0; start = 1'b0; op = 2'b00; operand_a = 32'h0; operand_b = 32'h0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = 32'h0;
      fork monitor(); join_none
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_hi", hi, 32'h0);
      chk("reset_lo", lo, 32'h0);
      chk("reset_dbz", div_by_zero, 1'b0);

      rst = 1'b1;
      issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      issue(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 0);
      issue(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 0);
      issue(2'b10, 32'd100, 32'h0, 0);
      issue(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      issue(2'b11, 32'hFFFF_FFF9, 32'h0, 0);
      issue(2'b00, 32'd6, 32'd7, 1);
      issue(DIV_EN ? 2'b10 : 2'b00, 32'hDEAD_BEEF, 32'd13, 3);
      mt(1'b1, 1'b0, 32'h1234_5678);
      mt(1'b0, 1'b1, 32'hCAFE_F00D);
      mt(1'b1, 1'b1, 32'h0BAD_F00D);
      issue(2'b00, 32'd3, 32'd5, 2);
      issue(2'b00, 32'h1234_5678, 32'h0, 0);
      issue(2'b01, 32'h8000_0000, 32'h8000_0000, 4);

      for (int i = 0; i < 24; i++) begin
         ro = 2'($urandom);
         ra = $urandom;
         rb = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'h0;
            1: rb = 32'($urandom_range(1, 9));
            2: ra = 32'($urandom_range(0, 50));
            default: ;
         endcase
         issue(ro, ra, rb, 0);
      end

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
